// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory fetch responder with a fixed-latency pipe and an ordered response queue
// Fetches read memory at accept time. The word travels a LATENCY-1 stage pipe, then waits in a queue until the consumer pops it.
module imem_responder #(
   parameter int DEPTH_WORDS     = 256,
   parameter int LATENCY         = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_ready,
   output logic        resp_valid,
   output logic [31:0] resp_instr,
   output logic        resp_fault,
   input  logic        resp_ready,
   input  logic        flush,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   logic [31:0]                mem [DEPTH_WORDS];
   logic [31:0]                q_instr [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] q_fault;
   logic [QW-1:0]              rd_ptr;
   logic [QW-1:0]              wr_ptr;
   logic [QW-1:0]              wr_idx;
   logic [OW-1:0]              q_count;
   logic [OW-1:0]              outstanding;

   logic        accept;
   logic        pop;
   logic        fetch_fault;
   logic [31:0] fetch_word;
   logic        push_v;
   logic [31:0] push_instr;
   logic        push_fault;
   logic        load_in_range;
   logic        unused_load_lsb;

   function automatic logic [QW-1:0] nxt(input logic [QW-1:0] p);
      return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign accept      = fetch_req & fetch_ready;
   assign pop         = resp_valid & resp_ready;
   assign fetch_ready = rst_n & ~load_en & ((outstanding < OW'(MAX_OUTSTANDING)) | pop);

   assign fetch_fault = (fetch_addr[1:0] != 2'b00) | (fetch_addr[31:AW+2] != '0);
   assign fetch_word  = fetch_fault ? 32'h0 : mem[fetch_addr[AW+1:2]];

   assign load_in_range   = (load_addr[31:AW+2] == '0);
   assign unused_load_lsb = ^load_addr[1:0];

   always_ff @(posedge clk) begin
      if (load_en && load_in_range)
         mem[load_addr[AW+1:2]] <= load_data;
   end

   generate
      if (LATENCY > 1) begin : g_pipe
         logic [LATENCY-2:0] pipe_v;
         logic [LATENCY-2:0] pipe_fault;
         logic [31:0]        pipe_instr [LATENCY-1];

         // A flush empties the pipe, but the request accepted alongside it still enters stage 0.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               pipe_v <= '0;
            end else begin
               for (int i = LATENCY - 2; i > 0; i--)
                  pipe_v[i] <= flush ? 1'b0 : pipe_v[i-1];
               pipe_v[0] <= accept;
            end
         end

         always_ff @(posedge clk) begin
            for (int i = LATENCY - 2; i > 0; i--) begin
               pipe_instr[i] <= pipe_instr[i-1];
               pipe_fault[i] <= pipe_fault[i-1];
            end
            pipe_instr[0] <= fetch_word;
            pipe_fault[0] <= fetch_fault;
         end

         assign push_v     = pipe_v[LATENCY-2];
         assign push_instr = pipe_instr[LATENCY-2];
         assign push_fault = pipe_fault[LATENCY-2];
      end else begin : g_direct
         assign push_v     = accept;
         assign push_instr = fetch_word;
         assign push_fault = fetch_fault;
      end
   endgenerate

   assign wr_idx = flush ? '0 : wr_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         q_count <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         // With a zero-stage pipe the redirect target lands straight in the emptied queue.
         if (LATENCY == 1 && accept) begin
            wr_ptr  <= nxt('0);
            q_count <= OW'(1);
         end else begin
            wr_ptr  <= '0;
            q_count <= '0;
         end
      end else begin
         if (push_v)
            wr_ptr <= nxt(wr_ptr);
         if (pop)
            rd_ptr <= nxt(rd_ptr);
         q_count <= q_count + OW'(push_v) - OW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push_v) begin
         q_instr[wr_idx] <= push_instr;
         q_fault[wr_idx] <= push_fault;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         outstanding <= '0;
      else if (flush)
         outstanding <= OW'(accept);
      else
         outstanding <= outstanding + OW'(accept) - OW'(pop);
   end

   assign resp_valid = (q_count != '0);
   assign resp_instr = resp_valid ? q_instr[rd_ptr] : 32'h0;
   assign resp_fault = resp_valid & q_fault[rd_ptr];

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed bench for imem_responder with an in-order response model
// The model keeps a list of expected responses stamped with the cycle at which each may first appear.
module tb_imem_responder;

   localparam int LAT   = 2;
   localparam int MAXO  = 4;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_req = 1'b1;
   logic [31:0] fetch_addr = 32'h0;
   logic        fetch_ready;
   logic        resp_valid;
   logic [31:0] resp_instr;
   logic        resp_fault;
   logic        resp_ready = 1'b1;
   logic        flush = 1'b0;
   logic        load_en = 1'b0;
   logic [31:0] load_addr = 32'h0;
   logic [31:0] load_data = 32'h0;

   imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(fetch_ready), .resp_valid(resp_valid), .resp_instr(resp_instr),
      .resp_fault(resp_fault), .resp_ready(resp_ready), .flush(flush),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   typedef struct {
      logic [31:0] instr;
      logic        fault;
      int          due;
   } ent_t;

   ent_t        q[$];
   logic [31:0] mm [DEPTH];
   int          cyc = 0;
   bit          started = 0;
   bit          m_valid = 0;
   bit          m_ready = 0;

   always @(negedge clk) begin
      if (started) begin
         m_valid = (q.size() > 0) && (q[0].due <= cyc);
         m_ready = rst_n && !load_en && ((q.size() < MAXO) || (m_valid && resp_ready));
         chk("fetch_ready", 32'(fetch_ready), 32'(m_ready));
         chk("resp_valid", 32'(resp_valid), 32'(m_valid));
         if (m_valid) begin
            chk("resp_instr", resp_instr, q[0].instr);
            chk("resp_fault", 32'(resp_fault), 32'(q[0].fault));
         end else if (!rst_n) begin
            chk("reset_instr", resp_instr, 32'h0);
            chk("reset_fault", 32'(resp_fault), 32'h0);
         end
      end
   end

   always @(posedge clk) begin
      ent_t e;
      bit   acc;
      bit   pop;
      if (!rst_n) begin
         q.delete();
      end else begin
         acc = fetch_req && m_ready;
         pop = m_valid && resp_ready;
         if (acc) begin
            e.fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= 32'(4 * DEPTH));
            e.instr = e.fault ? 32'h0 : mm[fetch_addr[9:2]];
            e.due   = cyc + LAT;
         end
         if (pop)
            void'(q.pop_front());
         if (flush)
            q.delete();
         if (acc)
            q.push_back(e);
      end
      if (load_en && load_addr < 32'(4 * DEPTH))
         mm[load_addr[9:2]] = load_data;
      started = 1;
      cyc++;
   end

   task automatic idle(input int n);
      @(posedge clk); #1;
      fetch_req = 0; flush = 0; load_en = 0; resp_ready = 1;
      repeat (n - 1) @(posedge clk);
   endtask

   initial begin
      int acc;

      // T1: reset held with a request pending
      repeat (3) begin
         @(negedge clk);
         chk("t1_ready_in_reset", 32'(fetch_ready), 32'h0);
         chk("t1_valid_in_reset", 32'(resp_valid), 32'h0);
      end
      @(posedge clk); #1;
      rst_n = 1; fetch_req = 0;
      @(negedge clk);
      chk("t1_ready_after_release", 32'(fetch_ready), 32'h1);

      for (int i = 0; i < DEPTH; i++) begin
         @(posedge clk); #1;
         load_en = 1; load_addr = 32'(i * 4); load_data = pat(i);
      end

      // T2: program load then back-to-back fetches
      @(posedge clk); #1;
      load_addr = 32'h0; load_data = 32'h2000_0001;
      @(posedge clk); #1;
      load_addr = 32'h4; load_data = 32'h8C01_0004;
      @(posedge clk); #1;
      load_en = 0; fetch_req = 1; fetch_addr = 32'h0;
      @(posedge clk); #1;
      fetch_addr = 32'h4;
      @(negedge clk);
      chk("t2_not_yet_valid", 32'(resp_valid), 32'h0);
      @(posedge clk); #1;
      fetch_req = 0;
      @(negedge clk);
      chk("t2_first_valid", 32'(resp_valid), 32'h1);
      chk("t2_first_instr", resp_instr, 32'h2000_0001);
      chk("t2_first_fault", 32'(resp_fault), 32'h0);
      @(negedge clk);
      chk("t2_second_instr", resp_instr, 32'h8C01_0004);

      // T3: misaligned and out-of-range fetches; out-of-range load ignored
      @(posedge clk); #1;
      load_en = 1; load_addr = 32'h400; load_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      load_en = 0; fetch_req = 1; fetch_addr = 32'h2;
      @(posedge clk); #1;
      fetch_req = 0;
      @(posedge clk);
      @(negedge clk);
      chk("t3_misaligned_fault", 32'(resp_fault), 32'h1);
      chk("t3_misaligned_instr", resp_instr, 32'h0);
      @(posedge clk); #1;
      fetch_req = 1; fetch_addr = 32'h400;
      @(posedge clk); #1;
      fetch_req = 0;
      @(posedge clk);
      @(negedge clk);
      chk("t3_range_fault", 32'(resp_fault), 32'h1);
      idle(3);

      // T4: backpressure caps acceptance at MAX_OUTSTANDING
      acc = 0;
      @(posedge clk); #1;
      resp_ready = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         fetch_req = 1; fetch_addr = 32'(32'h10 + 4 * acc);
         @(negedge clk);
         if (fetch_ready)
            acc++;
      end
      @(posedge clk); #1;
      fetch_req = 0;
      chk("t4_accept_count", 32'(acc), 32'd4);
      repeat (3) begin
         @(negedge clk);
         chk("t4_held_valid", 32'(resp_valid), 32'h1);
         chk("t4_held_instr", resp_instr, pat(4));
      end
      chk("t4_ready_full", 32'(fetch_ready), 32'h0);
      @(posedge clk); #1;
      resp_ready = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_drain_instr", resp_instr, pat(4 + k));
      end
      idle(3);

      // T5: flush with a same-cycle redirect fetch
      @(posedge clk); #1;
      resp_ready = 0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         fetch_req = 1; fetch_addr = 32'(32'h20 + 4 * i);
      end
      @(posedge clk); #1;
      flush = 1; fetch_addr = 32'h8;
      @(posedge clk); #1;
      flush = 0; fetch_req = 0; resp_ready = 1;
      @(negedge clk);
      chk("t5_cleared", 32'(resp_valid), 32'h0);
      @(negedge clk);
      chk("t5_target_valid", 32'(resp_valid), 32'h1);
      chk("t5_target_instr", resp_instr, pat(2));
      @(negedge clk);
      chk("t5_nothing_after", 32'(resp_valid), 32'h0);
      idle(2);

      // T6: a load behind an in-flight fetch does not alter it
      @(posedge clk); #1;
      fetch_req = 1; fetch_addr = 32'h0;
      @(posedge clk); #1;
      fetch_req = 0; load_en = 1; load_addr = 32'h0; load_data = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      load_en = 0;
      @(negedge clk);
      chk("t6_old_word", resp_instr, 32'h2000_0001);
      @(posedge clk); #1;
      fetch_req = 1; fetch_addr = 32'h0;
      @(posedge clk); #1;
      fetch_req = 0;
      @(posedge clk);
      @(negedge clk);
      chk("t6_new_word", resp_instr, 32'hFFFF_FFFF);
      idle(2);

      // T7: reset mid-flight drops the pending response
      @(posedge clk); #1;
      fetch_req = 1; fetch_addr = 32'h4;
      @(posedge clk); #1;
      fetch_req = 0; rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      chk("t7_dropped", 32'(resp_valid), 32'h0);

      idle(6);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
